// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared pipeline types used by the unified memory port arbiter
package rv32i_types;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_req_slot.sv
// rtl/mem_req_slot.sv - single-entry pending request holder for one arbiter side
module mem_req_slot
  import rv32i_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     capture,
  input  mem_req_t req_d,
  input  logic     clear,
  input  logic     flush,
  output logic     valid,
  output mem_req_t req_q
);

  // flush beats capture so a request arriving with a redirect is dropped
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      req_q <= req_d;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - imem/dmem arbiter for one unified memory port
// Optional perf counters (conflict_cnt, stall_cnt) under MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter bit DMEM_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  input  logic        imem_flush,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0] conflict_cnt,
  output logic [31:0] stall_cnt
`endif
);

  arb_state_t state, state_next;
  logic       discard;
  logic       i_valid, d_valid;
  mem_req_t   i_slot, d_slot;
  mem_req_t   i_in_req, d_in_req, i_req, d_req;
  logic       i_in, d_in, i_cand, d_cand;
  logic       can_grant, grant_i, grant_d;

  always_comb begin
    i_in_req  = '{addr: imem_addr, rmask: imem_rmask, wmask: 4'h0, wdata: 32'h0};
    d_in_req  = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};
    i_in      = (imem_rmask != 4'h0) && !imem_flush;
    d_in      = (dmem_rmask != 4'h0) || (dmem_wmask != 4'h0);
    i_cand    = (i_valid && !imem_flush) || i_in;
    d_cand    = d_valid || d_in;
    i_req     = i_valid ? i_slot : i_in_req;
    d_req     = d_valid ? d_slot : d_in_req;
    can_grant = (state == ARB_IDLE) || mem_resp;
    grant_d   = can_grant && d_cand && (!i_cand || DMEM_FIRST);
    grant_i   = can_grant && i_cand && (!d_cand || !DMEM_FIRST);
  end

  mem_req_slot u_imem_slot (
    .clk    (clk),
    .rst    (rst),
    .capture(i_in && !grant_i),
    .req_d  (i_in_req),
    .clear  (grant_i),
    .flush  (imem_flush),
    .valid  (i_valid),
    .req_q  (i_slot)
  );

  mem_req_slot u_dmem_slot (
    .clk    (clk),
    .rst    (rst),
    .capture(d_in && !grant_d),
    .req_d  (d_in_req),
    .clear  (grant_d),
    .flush  (1'b0),
    .valid  (d_valid),
    .req_q  (d_slot)
  );

  always_comb begin
    state_next = state;
    imem_resp  = 1'b0;
    dmem_resp  = 1'b0;
    imem_rdata = mem_rdata;
    dmem_rdata = mem_rdata;
    case (state)
      ARB_BUSY_I: begin
        imem_resp = mem_resp && !discard;
        if (mem_resp) state_next = ARB_IDLE;
      end
      ARB_BUSY_D: begin
        dmem_resp = mem_resp;
        if (mem_resp) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
    if (grant_d) state_next = ARB_BUSY_D;
    else if (grant_i) state_next = ARB_BUSY_I;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // the flushed fetch's response still closes the transaction, only its strobe is hidden
  always_ff @(posedge clk) begin
    if (rst) begin
      discard <= 1'b0;
    end else if (state == ARB_BUSY_I && mem_resp) begin
      discard <= 1'b0;
    end else if (state == ARB_BUSY_I && imem_flush) begin
      discard <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= 32'h0;
      mem_rmask <= 4'h0;
      mem_wmask <= 4'h0;
      mem_wdata <= 32'h0;
    end else begin
      mem_rmask <= 4'h0;
      mem_wmask <= 4'h0;
      if (grant_d) begin
        mem_addr  <= d_req.addr;
        mem_rmask <= d_req.rmask;
        mem_wmask <= d_req.wmask;
        mem_wdata <= d_req.wdata;
      end else if (grant_i) begin
        mem_addr  <= i_req.addr;
        mem_rmask <= i_req.rmask;
        mem_wmask <= i_req.wmask;
        mem_wdata <= i_req.wdata;
      end
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= 32'h0;
      stall_cnt    <= 32'h0;
    end else begin
      if ((grant_i || grant_d) && i_cand && d_cand && conflict_cnt != 32'hFFFF_FFFF)
        conflict_cnt <= conflict_cnt + 32'd1;
      if ((i_valid || d_valid) && state != ARB_IDLE && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter, both priority settings
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, mem_rdata;
  logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask;
  logic        imem_flush, mem_resp;

  logic [31:0] d_imem_rdata, d_dmem_rdata, d_mem_addr, d_mem_wdata;
  logic [3:0]  d_mem_rmask, d_mem_wmask;
  logic        d_imem_resp, d_dmem_resp;
  logic [31:0] i_imem_rdata, i_dmem_rdata, i_mem_addr, i_mem_wdata;
  logic [3:0]  i_mem_rmask, i_mem_wmask;
  logic        i_imem_resp, i_dmem_resp;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] d_conflict_cnt, d_stall_cnt, i_conflict_cnt, i_stall_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DMEM_FIRST(1'b1)) u_dfirst (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_flush(imem_flush),
    .imem_rdata(d_imem_rdata), .imem_resp(d_imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(d_dmem_rdata), .dmem_resp(d_dmem_resp),
    .mem_addr(d_mem_addr), .mem_rmask(d_mem_rmask), .mem_wmask(d_mem_wmask),
    .mem_wdata(d_mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
`ifdef MEM_ARB_PERF_CNT_EN
    , .conflict_cnt(d_conflict_cnt), .stall_cnt(d_stall_cnt)
`endif
  );

  mem_port_arbiter #(.DMEM_FIRST(1'b0)) u_ifirst (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_flush(imem_flush),
    .imem_rdata(i_imem_rdata), .imem_resp(i_imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(i_dmem_rdata), .dmem_resp(i_dmem_resp),
    .mem_addr(i_mem_addr), .mem_rmask(i_mem_rmask), .mem_wmask(i_mem_wmask),
    .mem_wdata(i_mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
`ifdef MEM_ARB_PERF_CNT_EN
    , .conflict_cnt(i_conflict_cnt), .stall_cnt(i_stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; imem_addr = '0; imem_rmask = '0; imem_flush = 1'b0;
    dmem_addr = '0; dmem_rmask = '0; dmem_wmask = '0; dmem_wdata = '0;
    mem_rdata = 32'h0BAD_F00D; mem_resp = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;

    check("rst_rmask", {28'h0, d_mem_rmask}, 32'h0);
    check("rst_wmask", {28'h0, d_mem_wmask}, 32'h0);
    check("rst_addr", d_mem_addr, 32'h0);
    check("rst_wdata", d_mem_wdata, 32'h0);
    check("rst_resps", {30'h0, d_imem_resp, d_dmem_resp}, 32'h0);
    check("rst_irdata", d_imem_rdata, 32'h0BAD_F00D);
    check("rst_drdata", d_dmem_rdata, 32'h0BAD_F00D);

    // single fetch
    imem_rmask = 4'hF; imem_addr = 32'h0000_1000;
    tick();
    imem_rmask = 4'h0;
    check("fetch_rmask", {28'h0, d_mem_rmask}, 32'hF);
    check("fetch_addr", d_mem_addr, 32'h0000_1000);
    tick();
    check("fetch_pulse_once", {28'h0, d_mem_rmask}, 32'h0);
    tick();
    mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
    #1;
    check("fetch_resp", {31'h0, d_imem_resp}, 32'h1);
    check("fetch_rdata", d_imem_rdata, 32'h0000_0013);
    check("fetch_no_dresp", {31'h0, d_dmem_resp}, 32'h0);
    tick();
    mem_resp = 1'b0;
    #1;
    check("fetch_resp_drop", {31'h0, d_imem_resp}, 32'h0);

    // simultaneous requests, both priorities
    imem_rmask = 4'hF; imem_addr = 32'h0000_1004;
    dmem_rmask = 4'hF; dmem_addr = 32'h0000_2000;
    tick();
    imem_rmask = 4'h0; dmem_rmask = 4'h0;
    check("conf_d_first_addr", d_mem_addr, 32'h0000_2000);
    check("conf_i_first_addr", i_mem_addr, 32'h0000_1004);
    check("conf_i_first_rmask", {28'h0, i_mem_rmask}, 32'hF);
    tick(); tick();
    mem_resp = 1'b1; mem_rdata = 32'h1111_1111;
    #1;
    check("conf1_d_first_resp", {30'h0, d_imem_resp, d_dmem_resp}, 32'h1);
    check("conf1_i_first_resp", {30'h0, i_imem_resp, i_dmem_resp}, 32'h2);
    tick();
    mem_resp = 1'b0;
    #1;
    check("conf2_d_first_addr", d_mem_addr, 32'h0000_1004);
    check("conf2_d_first_rmask", {28'h0, d_mem_rmask}, 32'hF);
    check("conf2_i_first_addr", i_mem_addr, 32'h0000_2000);
    tick();
    mem_resp = 1'b1; mem_rdata = 32'h2222_2222;
    #1;
    check("conf3_d_first_resp", {30'h0, d_imem_resp, d_dmem_resp}, 32'h2);
    check("conf3_d_first_rdata", d_imem_rdata, 32'h2222_2222);
    check("conf3_i_first_resp", {30'h0, i_imem_resp, i_dmem_resp}, 32'h1);
    tick();
    mem_resp = 1'b0;

    // store
    dmem_wmask = 4'h3; dmem_wdata = 32'h0000_BEEF; dmem_addr = 32'h0000_2002;
    tick();
    dmem_wmask = 4'h0;
    check("st_wmask", {28'h0, d_mem_wmask}, 32'h3);
    check("st_rmask", {28'h0, d_mem_rmask}, 32'h0);
    check("st_wdata", d_mem_wdata, 32'h0000_BEEF);
    check("st_addr", d_mem_addr, 32'h0000_2002);
    tick();
    mem_resp = 1'b1;
    #1;
    check("st_resp", {30'h0, d_imem_resp, d_dmem_resp}, 32'h1);
    tick();
    mem_resp = 1'b0;

    // flush while the fetch is in flight
    imem_rmask = 4'hF; imem_addr = 32'h0000_3000;
    tick();
    imem_rmask = 4'h0;
    check("fl_issue", d_mem_addr, 32'h0000_3000);
    tick();
    imem_flush = 1'b1;
    tick();
    imem_flush = 1'b0;
    tick();
    mem_resp = 1'b1; mem_rdata = 32'h0000_0066;
    #1;
    check("fl_no_resp_d", {31'h0, d_imem_resp}, 32'h0);
    check("fl_no_resp_i", {31'h0, i_imem_resp}, 32'h0);
    tick();
    mem_resp = 1'b0;
    imem_rmask = 4'hF; imem_addr = 32'h0000_3004;
    tick();
    imem_rmask = 4'h0;
    check("fl_new_addr", d_mem_addr, 32'h0000_3004);
    check("fl_new_rmask", {28'h0, d_mem_rmask}, 32'hF);
    tick();
    mem_resp = 1'b1; mem_rdata = 32'h0000_0077;
    #1;
    check("fl_new_resp", {31'h0, d_imem_resp}, 32'h1);
    check("fl_new_rdata", d_imem_rdata, 32'h0000_0077);
    tick();
    mem_resp = 1'b0;

    // flush a fetch queued behind a load
    dmem_rmask = 4'hF; dmem_addr = 32'h0000_4000;
    tick();
    dmem_rmask = 4'h0;
    check("fp_load_addr", d_mem_addr, 32'h0000_4000);
    imem_rmask = 4'hF; imem_addr = 32'h0000_5000;
    tick();
    imem_rmask = 4'h0; imem_flush = 1'b1;
    tick();
    imem_flush = 1'b0; mem_resp = 1'b1;
    #1;
    check("fp_dresp", {30'h0, d_imem_resp, d_dmem_resp}, 32'h1);
    tick();
    mem_resp = 1'b0;
    #1;
    check("fp_no_issue_rmask", {28'h0, d_mem_rmask}, 32'h0);
    check("fp_no_issue_addr", d_mem_addr, 32'h0000_4000);
    tick();
    check("fp_still_idle", {28'h0, i_mem_rmask}, 32'h0);

    // reset in the middle of a load
    dmem_rmask = 4'hF; dmem_addr = 32'h0000_6000;
    tick();
    dmem_rmask = 4'h0;
    check("rm_issue", d_mem_addr, 32'h0000_6000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_addr", d_mem_addr, 32'h0);
    check("rm_wdata", d_mem_wdata, 32'h0);
    mem_resp = 1'b1; mem_rdata = 32'h0000_0088;
    #1;
    check("rm_no_resp_d", {30'h0, d_imem_resp, d_dmem_resp}, 32'h0);
    check("rm_no_resp_i", {30'h0, i_imem_resp, i_dmem_resp}, 32'h0);
    check("rm_rdata_follow", d_dmem_rdata, 32'h0000_0088);
`ifdef MEM_ARB_PERF_CNT_EN
    check("rm_conflict_cnt", d_conflict_cnt, 32'h0);
    check("rm_stall_cnt", d_stall_cnt, 32'h0);
`endif
    tick();
    mem_resp = 1'b0;
    #1;
    check("rm_idle_rmask", {28'h0, d_mem_rmask}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
